// File: rtl/fetch_branch_unit_pkg.sv
// Shared types and default widths for the fetch/branch program-counter sequencer.
// No logic here; imported by the sequencer and its optional branch-target table.
// Backpressure: n/a.
package fetch_branch_unit_pkg;

    localparam int PC_W_DEF  = 10;
    localparam int CNT_W_DEF = 16;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        HALTED
    } fetch_state_e;

endpackage

// File: rtl/fetch_branch_unit_lut.sv
// Absolute branch-target table: one synchronous write port, one asynchronous read port.
// Latency: write visible after the CLK edge; read is combinational (same-cycle write not seen).
// Backpressure: none, a write is accepted on every edge where wr_vld is high.
module branch_target_lut #(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH),
    parameter int DW    = 10
) (
    input  logic          CLK,
    input  logic          RESET_N,
    input  logic          wr_vld,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_dat,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_dat
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_vld) begin
            mem[wr_addr] <= wr_dat;
        end
    end

    assign rd_dat = mem[rd_addr];

endmodule

// File: rtl/fetch_branch_unit.sv
// PC sequencer with run/halt control and saturating retire/taken counters; BR_LUT_EN selects absolute LUT branching.
// Latency: BR_FLAG sampled at edge N steers the PC visible right after edge N (no delay slot).
// Backpressure: STALL freezes PC, counters and state; HALT_REQ overrides STALL.
module fetch_branch_unit
    import fetch_branch_unit_pkg::*;
#(
    parameter int PC_W      = PC_W_DEF,
    parameter int CNT_W     = CNT_W_DEF,
    parameter int LUT_DEPTH = 16
) (
    input  logic                         CLK,
    input  logic                         RESET_N,
    input  logic                         START,
    input  logic [PC_W-1:0]              START_ADDR,
    input  logic                         STALL,
    input  logic                         BR_EN,
    input  logic                         BR_FLAG,
    input  logic [7:0]                   BR_OFFSET,
    input  logic                         HALT_REQ,
`ifdef BR_LUT_EN
    input  logic                         LUT_WE,
    input  logic [$clog2(LUT_DEPTH)-1:0] LUT_ADDR,
    input  logic [PC_W-1:0]              LUT_DATA,
`endif
    output logic [PC_W-1:0]              PC,
    output logic                         RUNNING,
    output logic                         DONE,
    output logic [CNT_W-1:0]             INST_COUNT,
    output logic [CNT_W-1:0]             TAKEN_COUNT
);

    fetch_state_e     state_q, state_nxt;
    logic [PC_W-1:0]  pc_q, pc_nxt, br_target;
    logic [CNT_W-1:0] inst_q, inst_nxt, taken_q, taken_nxt;
    logic             done_q, done_nxt;
    logic             br_taken;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // The ALU raises BR_FLAG for every BR op, so only the decoder's enable makes it meaningful.
    assign br_taken = BR_EN & BR_FLAG;

`ifdef BR_LUT_EN
    localparam int LUT_AW = $clog2(LUT_DEPTH);

    branch_target_lut #(
        .DEPTH (LUT_DEPTH),
        .AW    (LUT_AW),
        .DW    (PC_W)
    ) u_lut (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .wr_vld  (LUT_WE),
        .wr_addr (LUT_ADDR),
        .wr_dat  (LUT_DATA),
        .rd_addr (BR_OFFSET[LUT_AW-1:0]),
        .rd_dat  (br_target)
    );
`else
    assign br_target = pc_q + PC_W'($signed(BR_OFFSET));
`endif

    always_comb begin
        state_nxt = state_q;
        pc_nxt    = pc_q;
        inst_nxt  = inst_q;
        taken_nxt = taken_q;
        done_nxt  = done_q;
        case (state_q)
            RUN: begin
                if (HALT_REQ) begin
                    state_nxt = HALTED;
                    done_nxt  = 1'b1;
                    inst_nxt  = sat_inc(inst_q);
                end else if (!STALL) begin
                    inst_nxt = sat_inc(inst_q);
                    if (br_taken) begin
                        pc_nxt    = br_target;
                        taken_nxt = sat_inc(taken_q);
                    end else begin
                        pc_nxt = pc_q + PC_W'(1);
                    end
                end
            end
            default: begin
                if (START) begin
                    state_nxt = RUN;
                    pc_nxt    = START_ADDR;
                    inst_nxt  = '0;
                    taken_nxt = '0;
                    done_nxt  = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= IDLE;
            pc_q    <= '0;
            inst_q  <= '0;
            taken_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_nxt;
            pc_q    <= pc_nxt;
            inst_q  <= inst_nxt;
            taken_q <= taken_nxt;
            done_q  <= done_nxt;
        end
    end

    assign PC          = pc_q;
    assign RUNNING     = (state_q == RUN);
    assign DONE        = done_q;
    assign INST_COUNT  = inst_q;
    assign TAKEN_COUNT = taken_q;

endmodule

// File: tb/tb_fetch_branch_unit.sv
// Directed bench for fetch_branch_unit; small counter width so saturation is reachable quickly.
module tb_fetch_branch_unit;

    localparam int PC_W      = 10;
    localparam int CNT_W     = 6;
    localparam int LUT_DEPTH = 16;
    localparam int CNT_MAX   = (1 << CNT_W) - 1;

    logic             CLK;
    logic             RESET_N;
    logic             START;
    logic [PC_W-1:0]  START_ADDR;
    logic             STALL;
    logic             BR_EN;
    logic             BR_FLAG;
    logic [7:0]       BR_OFFSET;
    logic             HALT_REQ;
    logic             LUT_WE;
    logic [3:0]       LUT_ADDR;
    logic [PC_W-1:0]  LUT_DATA;
    logic [PC_W-1:0]  PC;
    logic             RUNNING;
    logic             DONE;
    logic [CNT_W-1:0] INST_COUNT;
    logic [CNT_W-1:0] TAKEN_COUNT;

    int n_cmp = 0;
    int n_bad = 0;

    fetch_branch_unit #(
        .PC_W      (PC_W),
        .CNT_W     (CNT_W),
        .LUT_DEPTH (LUT_DEPTH)
    ) dut (
        .CLK         (CLK),
        .RESET_N     (RESET_N),
        .START       (START),
        .START_ADDR  (START_ADDR),
        .STALL       (STALL),
        .BR_EN       (BR_EN),
        .BR_FLAG     (BR_FLAG),
        .BR_OFFSET   (BR_OFFSET),
        .HALT_REQ    (HALT_REQ),
`ifdef BR_LUT_EN
        .LUT_WE      (LUT_WE),
        .LUT_ADDR    (LUT_ADDR),
        .LUT_DATA    (LUT_DATA),
`endif
        .PC          (PC),
        .RUNNING     (RUNNING),
        .DONE        (DONE),
        .INST_COUNT  (INST_COUNT),
        .TAKEN_COUNT (TAKEN_COUNT)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge CLK);
        #2;
    endtask

    task automatic idle_inputs;
        START     = 1'b0;
        STALL     = 1'b0;
        BR_EN     = 1'b0;
        BR_FLAG   = 1'b0;
        BR_OFFSET = 8'h00;
        HALT_REQ  = 1'b0;
        LUT_WE    = 1'b0;
        LUT_ADDR  = 4'h0;
        LUT_DATA  = '0;
    endtask

    task automatic restart(input logic [PC_W-1:0] addr);
        idle_inputs();
        HALT_REQ = 1'b1;
        tick();
        idle_inputs();
        START      = 1'b1;
        START_ADDR = addr;
        tick();
        idle_inputs();
    endtask

    initial begin
        RESET_N    = 1'b0;
        START_ADDR = '0;
        idle_inputs();
        #12;
        check("rst_pc", 32'(PC), 32'h0);
        check("rst_running", 32'(RUNNING), 32'h0);
        check("rst_done", 32'(DONE), 32'h0);
        check("rst_inst", 32'(INST_COUNT), 32'h0);
        check("rst_taken", 32'(TAKEN_COUNT), 32'h0);
        RESET_N = 1'b1;

        tick();
        check("idle_hold", 32'(RUNNING), 32'h0);

        START = 1'b1; START_ADDR = 10'h010;
        tick();
        START = 1'b0;
        check("start_running", 32'(RUNNING), 32'h1);
        check("start_pc", 32'(PC), 32'h010);
        check("start_inst", 32'(INST_COUNT), 32'h0);
        tick();
        check("seq_pc1", 32'(PC), 32'h011);
        tick();
        check("seq_pc2", 32'(PC), 32'h012);
        check("seq_inst2", 32'(INST_COUNT), 32'h2);

        START = 1'b1; START_ADDR = 10'h100;
        tick();
        START = 1'b0;
        check("start_in_run_pc", 32'(PC), 32'h013);
        check("start_in_run_inst", 32'(INST_COUNT), 32'h3);

        HALT_REQ = 1'b1;
        tick();
        HALT_REQ = 1'b0;
        check("halt_running", 32'(RUNNING), 32'h0);
        check("halt_done", 32'(DONE), 32'h1);
        check("halt_pc", 32'(PC), 32'h013);
        check("halt_inst", 32'(INST_COUNT), 32'h4);
        BR_EN = 1'b1; BR_FLAG = 1'b1; BR_OFFSET = 8'h05;
        tick();
        idle_inputs();
        check("halted_frozen_pc", 32'(PC), 32'h013);
        check("halted_frozen_done", 32'(DONE), 32'h1);

`ifndef BR_LUT_EN
        restart(10'h020);
        check("restart_done", 32'(DONE), 32'h0);
        check("restart_inst", 32'(INST_COUNT), 32'h0);
        BR_EN = 1'b1; BR_FLAG = 1'b1; BR_OFFSET = 8'hFC;
        tick();
        idle_inputs();
        check("br_back_pc", 32'(PC), 32'h01C);
        check("br_back_taken", 32'(TAKEN_COUNT), 32'h1);
        check("br_back_inst", 32'(INST_COUNT), 32'h1);

        restart(10'h020);
        BR_EN = 1'b0; BR_FLAG = 1'b1; BR_OFFSET = 8'hFC;
        tick();
        idle_inputs();
        check("flag_no_en_pc", 32'(PC), 32'h021);
        check("flag_no_en_taken", 32'(TAKEN_COUNT), 32'h0);

        restart(10'h3FF);
        tick();
        check("seq_wrap_pc", 32'(PC), 32'h000);

        restart(10'h002);
        BR_EN = 1'b1; BR_FLAG = 1'b1; BR_OFFSET = 8'hF8;
        tick();
        idle_inputs();
        check("br_wrap_pc", 32'(PC), 32'h3FA);
`else
        LUT_WE = 1'b1; LUT_ADDR = 4'h3; LUT_DATA = 10'h155;
        tick();
        idle_inputs();
        restart(10'h020);
        BR_EN = 1'b1; BR_FLAG = 1'b1; BR_OFFSET = 8'h13;
        tick();
        idle_inputs();
        check("lut_br_pc", 32'(PC), 32'h155);
        check("lut_br_taken", 32'(TAKEN_COUNT), 32'h1);
        LUT_WE = 1'b1; LUT_ADDR = 4'h3; LUT_DATA = 10'h0AA;
        BR_EN = 1'b1; BR_FLAG = 1'b1; BR_OFFSET = 8'h03;
        tick();
        idle_inputs();
        check("lut_wr_rd_old", 32'(PC), 32'h155);
        BR_EN = 1'b1; BR_FLAG = 1'b1; BR_OFFSET = 8'h03;
        tick();
        idle_inputs();
        check("lut_new_val", 32'(PC), 32'h0AA);
        BR_EN = 1'b1; BR_FLAG = 1'b1; BR_OFFSET = 8'h07;
        tick();
        idle_inputs();
        check("lut_reset_entry", 32'(PC), 32'h000);
`endif

        restart(10'h040);
        STALL = 1'b1;
        repeat (3) tick();
        check("stall_pc", 32'(PC), 32'h040);
        check("stall_inst", 32'(INST_COUNT), 32'h0);
        check("stall_running", 32'(RUNNING), 32'h1);
        HALT_REQ = 1'b1;
        tick();
        idle_inputs();
        check("halt_stall_running", 32'(RUNNING), 32'h0);
        check("halt_stall_done", 32'(DONE), 32'h1);
        check("halt_stall_inst", 32'(INST_COUNT), 32'h1);
        check("halt_stall_pc", 32'(PC), 32'h040);
        START = 1'b1; START_ADDR = 10'h123;
        tick();
        START = 1'b0;
        check("restart2_done", 32'(DONE), 32'h0);
        check("restart2_pc", 32'(PC), 32'h123);
        check("restart2_running", 32'(RUNNING), 32'h1);

        restart(10'h000);
        BR_EN = 1'b1; BR_FLAG = 1'b1; BR_OFFSET = 8'h00;
        repeat (CNT_MAX + 7) tick();
        idle_inputs();
        check("sat_inst", 32'(INST_COUNT), 32'(CNT_MAX));
        check("sat_taken", 32'(TAKEN_COUNT), 32'(CNT_MAX));
        repeat (3) tick();
        check("sat_inst_hold", 32'(INST_COUNT), 32'(CNT_MAX));
        check("sat_taken_hold", 32'(TAKEN_COUNT), 32'(CNT_MAX));

        @(posedge CLK);
        #4;
        RESET_N = 1'b0;
        #1;
        check("async_rst_pc", 32'(PC), 32'h0);
        check("async_rst_running", 32'(RUNNING), 32'h0);
        check("async_rst_inst", 32'(INST_COUNT), 32'h0);
        check("async_rst_taken", 32'(TAKEN_COUNT), 32'h0);
        #2;
        RESET_N = 1'b1;
        tick();
        check("post_rst_idle", 32'(RUNNING), 32'h0);
        check("post_rst_pc", 32'(PC), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fetch_branch_unit.md
Name: fetch_branch_unit

Overview:
Program-counter sequencer for the 8-bit core. It sits on the consuming side of the ALU branch interface.
- Takes the ALU's combinational BR_FLAG, qualified by the decoder's branch-enable, and decides the next PC each cycle.
- Also owns run/halt control and the instruction and taken-branch counters used by the lab test harness.

Parameters:
PC_W, 10, width of program counter / instruction memory address
CNT_W, 16, width of instruction and taken-branch counters
LUT_DEPTH, 16, number of absolute branch targets (used only with BR_LUT_EN)

Ports:
CLK  input  1  single system clock, all state on rising edge
RESET_N  input  1  asynchronous, active-low reset
START  input  1  pulse: load START_ADDR and begin execution
START_ADDR  input  PC_W  first instruction address
STALL  input  1  hold PC and counters this cycle
BR_EN  input  1  current instruction is a branch (from decoder)
BR_FLAG  input  1  ALU branch condition, combinational, same cycle
BR_OFFSET  input  8  signed branch displacement from instruction field
HALT_REQ  input  1  current instruction is halt
PC  output  PC_W  current instruction address
RUNNING  output  1  high in RUN state
DONE  output  1  sticky; set on halt, cleared by START
INST_COUNT  output  CNT_W  retired (non-stalled RUN) cycles
TAKEN_COUNT  output  CNT_W  taken branches

Behaviour:
- Reset (async, RESET_N=0):
  - state=IDLE, PC=0, DONE=0, RUNNING=0, INST_COUNT=0, TAKEN_COUNT=0.
  - Release takes effect on the next CLK edge.
- States: IDLE, RUN, HALTED. RUNNING = (state==RUN), registered.
- IDLE:
  - START=1 -> RUN next cycle; PC<=START_ADDR; both counters<=0; DONE<=0.
  - All other inputs ignored.
- RUN, per-cycle priority HALT_REQ > STALL > taken branch > sequential:
  - HALT_REQ=1: ->HALTED, DONE<=1, PC held, INST_COUNT+1. Halt wins even when STALL=1 in the same cycle.
  - STALL=1: PC, counters and state all held.
  - Taken branch (BR_EN & BR_FLAG): PC<=PC+sext(BR_OFFSET), truncated to PC_W so it wraps modulo 2^PC_W. INST_COUNT+1, TAKEN_COUNT+1.
  - BR_FLAG with BR_EN=0 is ignored, because the ALU asserts BR_FLAG unconditionally for its BR op.
  - Otherwise: PC<=PC+1, with PC=2^PC_W-1 wrapping to 0. INST_COUNT+1.
  - START while in RUN is ignored.
- HALTED:
  - Outputs frozen.
  - START=1 -> RUN: same loading as from IDLE, DONE cleared on that edge.
- Counters saturate at 2^CNT_W-1 and never wrap.
- Latency: BR_FLAG sampled at edge N gives the new PC visible after edge N. There is no delay slot.
- Reset asserted mid-RUN: immediate return to IDLE with all reset values.

Optional Feature:
- Macro: BR_LUT_EN.
- Defined:
  - Adds input ports LUT_WE (1), LUT_ADDR ($clog2(LUT_DEPTH)) and LUT_DATA (PC_W).
  - Each LUT entry resets to 0; a write lands on the CLK edge while LUT_WE=1, in any state.
  - A taken branch loads PC<=LUT[BR_OFFSET[$clog2(LUT_DEPTH)-1:0]] (absolute target); upper offset bits are ignored.
  - A write and a read of the same entry in one cycle: the branch uses the old value.
- Undefined: LUT ports absent; relative branching as above.

Decomposition:
- Shared package definitionsABC gains:
  - typedef enum logic [1:0] {IDLE, RUN, HALTED} fetch_state_e;
  - localparams PC_W_DEF=10 and CNT_W_DEF=16.
- Sub-module branch_target_lut (register file, 1 write port, 1 async read port), instantiated only under BR_LUT_EN.

Test Plan:
- Reset then START with START_ADDR=0x010 -> RUNNING=1; PC=0x010, 0x011, 0x012 on successive edges; INST_COUNT=2 after the second advance.
- At PC=0x020, BR_EN=1, BR_FLAG=1, BR_OFFSET=0xFC (-4) -> PC=0x01C, TAKEN_COUNT=1. Same stimulus with BR_EN=0 -> PC=0x021, TAKEN_COUNT unchanged.
- PC=0x3FF with no branch -> PC=0x000. PC=0x002 with taken offset -8 -> PC=0x3FA.
- STALL=1 for 3 cycles at PC=0x040 -> PC and INST_COUNT unchanged; then HALT_REQ=1 together with STALL=1 -> HALTED, DONE=1, INST_COUNT+1. A later START clears DONE and PC=START_ADDR.
- RESET_N dropped asynchronously mid-cycle in RUN -> outputs zero before the next CLK edge; state IDLE.
- With BR_LUT_EN: write LUT[3]=0x155, then taken branch with BR_OFFSET=0x13 -> PC=0x155. Write LUT[3]=0x0AA in the same cycle as a taken branch to index 3 -> PC=0x155.
